// File: rtl/wide_add_pkg.sv
// Shared definitions for the byte-serial wide adder controller.
// Holds the controller state encoding and the latency of the companion
// 8-bit pipelined adder, so both sides of the interface agree on timing.
package wide_add_pkg;

   // Controller states; the encoding is fixed because other blocks decode it.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Issue-to-result latency of pipe_adder_8bit, in cycles.
   localparam int ADDER_LAT = 5;

endpackage

// File: rtl/wide_add_seq.sv
// Purpose : adds two W-bit operands plus carry-in, one byte slice at a time,
//           through an external 8-bit pipelined adder (pipe_adder_8bit).
// Latency : NB*(LAT+1)+1 cycles from the accepting edge to the Done pulse.
// Backpressure: none; Start is only looked at in IDLE, so a requester must
//           hold or re-assert it until Busy shows the request was taken.
//
// Ports:
//   Clk, Rst        clock, asynchronous active-high reset
//   Start           request, sampled in IDLE only
//   A, B, Cin       operands and carry-in, captured on the accepting edge
//   X, Y, AddCin    byte operands / carry-in to the adder (0 outside ISSUE)
//   Sum, Cout       adder result, sampled only in the capture cycle
//   Busy            high while a byte is being issued or awaited
//   Done            one-cycle pulse when R/Co are valid
//   R, Co           assembled W-bit sum and final carry-out
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int W   = 32,
   parameter int LAT = ADDER_LAT
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Cin,
   output logic [7:0]   X,
   output logic [7:0]   Y,
   output logic         AddCin,
   input  logic [7:0]   Sum,
   input  logic         Cout,
   output logic         Busy,
   output logic         Done,
   output logic [W-1:0] R,
   output logic         Co
);

   localparam int NB = W / 8;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [KW-1:0] K_LAST   = KW'(NB - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

   state_t                  state;
   logic [KW-1:0]           k;       // byte slice currently in flight
   logic [CW-1:0]           cnt;     // cycles left until the adder result
   logic [NB-1:0][7:0]      a_q;
   logic [NB-1:0][7:0]      b_q;
   logic [NB-1:0][7:0]      r_q;
   logic [KW-1:0]           k_nxt;

   assign k_nxt = k + 1'b1;
   assign R     = r_q;

   // X/Y/AddCin are registered: they are loaded on the edge that enters
   // ISSUE and fall back to zero on every other edge, so the adder sees
   // clean zeros in all non-issue cycles.
   // The carry into byte k+1 is taken straight from Cout on the capture
   // edge of byte k, which is the same value a separately stored carry
   // would hold one cycle later.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state  <= ST_IDLE;
         k      <= '0;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         X      <= '0;
         Y      <= '0;
         AddCin <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Co     <= 1'b0;
      end else begin
         X      <= '0;
         Y      <= '0;
         AddCin <= 1'b0;
         Done   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (Start) begin
                  a_q    <= A;
                  b_q    <= B;
                  k      <= '0;
                  X      <= A[7:0];
                  Y      <= B[7:0];
                  AddCin <= Cin;
                  Busy   <= 1'b1;
                  state  <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               cnt   <= CNT_LOAD;
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (cnt == '0) begin
                  r_q[k] <= Sum;
                  if (k == K_LAST) begin
                     Co    <= Cout;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     k      <= k_nxt;
                     X      <= a_q[k_nxt];
                     Y      <= b_q[k_nxt];
                     AddCin <= Cout;
                     state  <= ST_ISSUE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Byte-serial wide-operand adder controller that sits directly upstream of `pipe_adder_8bit` and consumes its results. It accepts a W-bit operand pair with a start handshake and issues one byte pair at a time into the 8-bit pipelined adder. It chains each returned `Cout` into the next byte's carry-in and assembles the W-bit sum plus carry-out. The adder is instantiated beside this block at the level above, not inside it.

## Interface
- `W`, 32, operand width; multiple of 8, at least 8; NB = W/8 byte slices.
- `LAT`, 5, cycles from adder issue cycle to the cycle in which `Sum`/`Cout` are valid; must match `pipe_adder_8bit`.
- `Clk`  in  1  clock; all state changes on rising edge.
- `Rst`  in  1  reset; asynchronous, active-high.
- `Start`  in  1  request; sampled only in IDLE.
- `A`, `B`  in  W  operands; captured on the accepting edge.
- `Cin`  in  1  carry-in to byte 0; captured with `A`/`B`.
- `X`, `Y`  out  8  byte operands to the adder.
- `AddCin`  out  1  carry-in to the adder.
- `Sum`  in  8  adder result byte.
- `Cout`  in  1  adder carry-out.
- `Busy`  out  1  high in ISSUE and WAIT.
- `Done`  out  1  one-cycle pulse when `R`/`Co` become valid.
- `R`  out  W  assembled sum.
- `Co`  out  1  carry-out of the most significant byte.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, `Start`=1: latch `A`, `B` and `Cin`; clear the byte index k to 0; go to ISSUE.
- ISSUE (1 cycle):
  - drive `X`=A[8k+7:8k] and `Y`=B[8k+7:8k];
  - drive `AddCin`=`Cin` for k=0, otherwise the carry stored from byte k-1;
  - load the wait counter with LAT-1; go to WAIT.
- WAIT: decrement the counter each cycle. On the cycle with counter = 0 (issue cycle + LAT):
  - write `Sum` into R[8k+7:8k] and store `Cout`;
  - if k = NB-1, go to DONE; otherwise increment k and go to ISSUE.
- DONE (1 cycle): `Done`=1, `Co` = stored carry; go to IDLE.
- Outside ISSUE, `X`, `Y` and `AddCin` are driven to 0 (deterministic adder input).
- `Start` is ignored in ISSUE, WAIT and DONE. A `Start` pulse in DONE is dropped; the requester must hold or re-assert it in IDLE.
- `R`/`Co` hold their value from DONE until the next accepted `Start`. They are not cleared on `Start`, but byte slices are overwritten progressively.
- Adder outputs are sampled only in the capture cycle. Stale or garbage adder outputs in any other cycle have no effect.
- Arithmetic: {Co, R} = A + B + Cin, modulo 2^(W+1) (exact, no truncation).

## Timing
- Accepting edge = E0; cycle n is the cycle after edge E0+n-1.
- Byte k issue cycle = 1 + k(LAT+1). Capture cycle = 1 + LAT + k(LAT+1).
- With defaults: issues at cycles 1, 7, 13, 19; captures at 6, 12, 18, 24; `Done`=1 in cycle 25.
- Total latency = NB(LAT+1)+1 cycles from E0 to `Done`.
- Back-to-back: the next `Start` can be accepted at the edge ending cycle 26 (IDLE).
- Reset values: state IDLE, `Busy`=0, `Done`=0, `R`=0, `Co`=0, `X`=`Y`=0, `AddCin`=0, k=0, counter=0.
- Reset mid-operation aborts immediately with no `Done`. Results still in flight in the adder are never captured, because the block is in IDLE.

## Structure
- Shared package `wide_add_pkg`: state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the `ADDER_LAT` = 5 constant.
- Single flat module, no sub-module.
- The top level instantiates `pipe_adder_8bit` and wires `X`/`Y`/`AddCin` to its `X`/`Y`/`Cin`, and its `Sum`/`Cout` back.

## Test plan
- A=0x0000_0001, B=0x0000_0002, Cin=0 -> `Done` in cycle 25; R=0x0000_0003, Co=0.
- A=0x00FF_FFFF, B=0x0000_0001, Cin=0 -> carry ripples through bytes 0–2; R=0x0100_0000, Co=0.
- A=0xFFFF_FFFF, B=0x0000_0000, Cin=1 -> R=0x0000_0000, Co=1; `AddCin`=1 observed in all four issue cycles.
- `Start` held high continuously with new operands after each `Done` -> accepted only in IDLE, once per 26 cycles. `Busy` is low exactly in the DONE and IDLE cycles.
- `Rst` asserted in cycle 10 of an op, released, then new op A=5, B=7 -> no `Done` for the aborted op; second op gives R=12, Co=0.
- 1000 random A/B/Cin vs. reference model -> {Co,R} = A+B+Cin. `X`/`Y`/`AddCin` are 0 in every non-ISSUE cycle.
